// File: rtl/sp_ram_arbiter_if.sv
// Requester-side command/response channel for sp_ram_arbiter.
// The arbiter takes one instance per requester through the slave modport.
interface sp_ram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Two-requester arbiter in front of a single-port async RAM with a shared tristate data bus.
// Define SP_RAM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module sp_ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  sp_ram_arbiter_if.slave       req0,
  sp_ram_arbiter_if.slave       req1,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StRdata} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  port_q;
  logic                  grant0, grant1;
  logic                  accept0, accept1, accept;
  logic                  sel_we;
  logic                  drive;
  logic                  rsp0_valid_q, rsp1_valid_q;
  logic [DATA_WIDTH-1:0] rsp0_rdata_q, rsp1_rdata_q;

`ifdef SP_RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = req0.valid;
    grant1 = req1.valid & ~req0.valid;
  end
`else
  // last_grant_q = 1 means port 1 was served last, so port 0 wins the next tie.
  logic last_grant_q;

  always_comb begin
    grant0 = req0.valid & (~req1.valid | last_grant_q);
    grant1 = req1.valid & (~req0.valid | ~last_grant_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= accept1;
    end
  end
`endif

  // Ready depends only on valids and registered state, never on ram_data.
  assign req0.ready = ~rst & (state_q == StIdle) & grant0;
  assign req1.ready = ~rst & (state_q == StIdle) & grant1;

  assign accept0 = req0.valid & req0.ready;
  assign accept1 = req1.valid & req1.ready;
  assign accept  = accept0 | accept1;
  assign sel_we  = accept1 ? req1.we : req0.we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ram_cs  = 1'b0;
    ram_we  = 1'b0;
    ram_oe  = 1'b0;
    drive   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = sel_we ? StWrite : StRead;
        end
      end
      StWrite: begin
        ram_cs  = 1'b1;
        ram_we  = 1'b1;
        drive   = 1'b1;
        state_d = StIdle;
      end
      StRead: begin
        ram_cs  = 1'b1;
        state_d = StRdata;
      end
      StRdata: begin
        ram_cs  = 1'b1;
        ram_oe  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Strobes and bus drive are suppressed for as long as reset is held.
    if (rst) begin
      ram_cs = 1'b0;
      ram_we = 1'b0;
      ram_oe = 1'b0;
      drive  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      port_q  <= 1'b0;
    end else if (accept) begin
      addr_q  <= accept1 ? req1.addr  : req0.addr;
      wdata_q <= accept1 ? req1.wdata : req0.wdata;
      port_q  <= accept1;
    end
  end

  assign ram_addr = addr_q;
  assign ram_data = drive ? wdata_q : 'z;

  // Completion fires on the edge that ends WRITE or RDATA; write completions return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      if ((state_q == StWrite) || (state_q == StRdata)) begin
        if (port_q) begin
          rsp1_valid_q <= 1'b1;
          rsp1_rdata_q <= (state_q == StRdata) ? ram_data : '0;
        end else begin
          rsp0_valid_q <= 1'b1;
          rsp0_rdata_q <= (state_q == StRdata) ? ram_data : '0;
        end
      end
    end
  end

  assign req0.rsp_valid = rsp0_valid_q;
  assign req0.rsp_rdata = rsp0_rdata_q;
  assign req1.rsp_valid = rsp1_valid_q;
  assign req1.rsp_rdata = rsp1_rdata_q;

endmodule
